dbi_ac_encoder: RTL and testbench

- Transmit-side DBI-AC encoder stage.
- It registers incoming bytes and computes the 9-line transition vector for each byte lane against the word last driven on the bus. The per-lane inversion decision is the 9-input majority (at least 5 of 9 lines would toggle), which is the function of the existing 9-input decision cell.
- Based on that decision it drives either the true or the inverted byte plus a DBI line.
- It sits between the write-data FIFO and the PHY serializer, with valid/ready on both sides. A saturating counter tracks inverted lanes.

---
 rtl/dbi_ac_encoder.sv | 64 ++++++
 tb/tb_dbi_ac_encoder.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/dbi_ac_encoder.sv
// dbi_ac_encoder: two-stage DBI-AC encoder with valid/ready handshake and saturating inversion counter
module dbi_ac_encoder #(
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic [LANES-1:0]   out_dbi,
  output logic [CNT_W-1:0]   inv_count,
  input  logic               clr_count
);
  logic               a_valid, rdy_en, a_to_b;
  logic [8*LANES-1:0] a_data, enc;
  logic [LANES-1:0]   inv;
  logic [3:0]         pc, n_inv;
  logic [CNT_W:0]     sum;
  logic [CNT_W-1:0]   sat;
  assign a_to_b   = a_valid && (!out_valid || out_ready);
  // rdy_en keeps in_ready low while reset is held and until the first edge after release
  assign in_ready = rdy_en && (!a_valid || a_to_b);
  // transition vector counts the DBI line as if the lane were sent true (DBI=0)
  always_comb begin
    inv   = '0;
    n_inv = '0;
    pc    = '0;
    enc   = a_data;
    for (int k = 0; k < LANES; k++) begin
      pc = 4'(out_dbi[k]);
      for (int i = 0; i < 8; i++) pc = pc + 4'(a_data[8*k+i] ^ out_data[8*k+i]);
      inv[k]       = pc >= 4'd5;
      n_inv        = n_inv + 4'(inv[k]);
      enc[8*k +: 8] = inv[k] ? ~a_data[8*k +: 8] : a_data[8*k +: 8];
    end
  end
  assign sum = {1'b0, inv_count} + (CNT_W+1)'(n_inv);
  assign sat = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_en    <= 1'b0;
      a_valid   <= 1'b0;
      a_data    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_dbi   <= '0;
      inv_count <= '0;
    end else begin
      rdy_en    <= 1'b1;
      a_valid   <= (in_valid && in_ready) || (a_valid && !a_to_b);
      if (in_valid && in_ready) a_data <= in_data;
      out_valid <= a_to_b || (out_valid && !out_ready);
      if (a_to_b) begin
        out_data <= enc;
        out_dbi  <= inv;
      end
      inv_count <= clr_count ? '0 : a_to_b ? sat : inv_count;
    end
  end
endmodule

// File: tb/tb_dbi_ac_encoder.sv
// tb_dbi_ac_encoder: directed self-checking bench for dbi_ac_encoder (LANES=4, CNT_W=4)
module tb_dbi_ac_encoder;
  logic        clk, rst, in_valid, in_ready, out_valid, out_ready, clr_count;
  logic [31:0] in_data, out_data;
  logic [3:0]  out_dbi, inv_count;
  int n_tests = 0, n_fail = 0;

  dbi_ac_encoder #(.LANES(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_dbi(out_dbi),
    .inv_count(inv_count), .clr_count(clr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; clr_count = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic push_word(input logic [31:0] d);
    in_valid = 1'b1; in_data = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; clr_count = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_tests++; if (out_data !== 32'h0 || out_dbi !== 4'h0) begin n_fail++; $display("FAIL reset_out: got %h/%b expected 0/0", out_data, out_dbi); end
    n_tests++; if (inv_count !== 4'h0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", inv_count); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_single_word();
    do_reset();
    push_word(32'h0000_0000);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL latency_early: got out_valid=%b expected 0", out_valid); end
    tick();
    n_tests++; if (out_valid !== 1'b1 || out_data !== 32'h0 || out_dbi !== 4'h0 || inv_count !== 4'd0) begin
      n_fail++; $display("FAIL zero_word: got v=%b %h/%b cnt=%0d expected 1 00000000/0000 0", out_valid, out_data, out_dbi, inv_count); end
    tick();
    n_tests++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin n_fail++; $display("FAIL idle_hold: got v=%b %h expected 0 00000000", out_valid, out_data); end
    push_word(32'h0000_00FF);
    tick();
    n_tests++; if (out_data !== 32'h0 || out_dbi !== 4'b0001 || inv_count !== 4'd1) begin
      n_fail++; $display("FAIL all_toggle: got %h/%b cnt=%0d expected 00000000/0001 1", out_data, out_dbi, inv_count); end
    push_word(32'h0000_000F);
    tick();
    n_tests++; if (out_data !== 32'h0000_00F0 || out_dbi !== 4'b0001 || inv_count !== 4'd2) begin
      n_fail++; $display("FAIL dbi_weight: got %h/%b cnt=%0d expected 000000f0/0001 2", out_data, out_dbi, inv_count); end
  endtask

  task automatic test_tie();
    do_reset();
    push_word(32'h0000_000F);
    tick();
    n_tests++; if (out_data !== 32'h0000_000F || out_dbi !== 4'b0000) begin
      n_fail++; $display("FAIL tie_true: got %h/%b expected 0000000f/0000", out_data, out_dbi); end
    push_word(32'h0000_00F0);
    tick();
    n_tests++; if (out_data !== 32'h0000_000F || out_dbi !== 4'b0001 || inv_count !== 4'd1) begin
      n_fail++; $display("FAIL tie_then_invert: got %h/%b cnt=%0d expected 0000000f/0001 1", out_data, out_dbi, inv_count); end
  endtask

  task automatic test_backpressure();
    logic [31:0] w  [6] = '{32'hFF00_0F01, 32'hFFFF_FFFF, 32'h0000_0000, 32'h1234_5678, 32'hEDCB_A987, 32'h0F0F_F0F0};
    logic [31:0] ed [6] = '{32'h0000_0F01, 32'h0000_FF00, 32'h0000_FF00, 32'h1234_A978, 32'h1234_A978, 32'hF0F0_F0F0};
    logic [3:0]  eb [6] = '{4'b1000, 4'b1101, 4'b0010, 4'b0010, 4'b1101, 4'b1100};
    logic [31:0] rd [6];
    logic [3:0]  rb [6];
    int idx = 0, nr = 0;
    logic acc;
    do_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_data = w[idx];
      #3 acc = in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    n_tests++; if (idx !== 2) begin n_fail++; $display("FAIL stall_accepts: got %0d expected 2", idx); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b expected 0", in_ready); end
    n_tests++; if (out_valid !== 1'b1 || out_data !== ed[0] || out_dbi !== eb[0]) begin
      n_fail++; $display("FAIL stall_stable: got v=%b %h/%b expected 1 %h/%b", out_valid, out_data, out_dbi, ed[0], eb[0]); end
    out_ready = 1'b1;
    for (int c = 0; c < 30 && nr < 6; c++) begin
      in_valid = idx < 6; in_data = w[idx < 6 ? idx : 0];
      #3 acc = in_valid && in_ready;
      if (out_valid) begin rd[nr] = out_data; rb[nr] = out_dbi; nr++; end
      @(posedge clk); #1;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    n_tests++; if (nr !== 6) begin n_fail++; $display("FAIL drain_count: got %0d expected 6", nr); end
    for (int i = 0; i < nr; i++) begin
      n_tests++; if (rd[i] !== ed[i] || rb[i] !== eb[i]) begin
        n_fail++; $display("FAIL drain_word%0d: got %h/%b expected %h/%b", i, rd[i], rb[i], ed[i], eb[i]); end
    end
    n_tests++; if (inv_count !== 4'd11) begin n_fail++; $display("FAIL bp_count: got %0d expected 11", inv_count); end
  endtask

  task automatic test_saturation();
    logic [3:0] exp_cnt [5] = '{4'd4, 4'd8, 4'd12, 4'd15, 4'd15};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push_word(32'hFFFF_FFFF);
      tick();
      n_tests++; if (inv_count !== exp_cnt[i] || out_dbi !== 4'b1111) begin
        n_fail++; $display("FAIL sat_step%0d: got cnt=%0d dbi=%b expected %0d 1111", i, inv_count, out_dbi, exp_cnt[i]); end
    end
    push_word(32'hFFFF_FFFF);
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    n_tests++; if (inv_count !== 4'd0 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL clr_priority: got cnt=%0d v=%b expected 0 1", inv_count, out_valid); end
  endtask

  task automatic test_async_reset();
    do_reset();
    push_word(32'hFFFF_FFFF);
    in_valid = 1'b1; in_data = 32'h00FF_00FF;
    tick();
    #2 rst = 1'b1;
    #1;
    n_tests++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_dbi !== 4'h0 || inv_count !== 4'd0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got v=%b %h/%b cnt=%0d rdy=%b expected 0 00000000/0000 0 0", out_valid, out_data, out_dbi, inv_count, in_ready); end
    in_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flushed: got out_valid=%b expected 0", out_valid); end
    push_word(32'h0F0F_0F0F);
    tick();
    n_tests++; if (out_data !== 32'h0F0F_0F0F || out_dbi !== 4'b0000 || inv_count !== 4'd0) begin
      n_fail++; $display("FAIL post_reset_ref: got %h/%b cnt=%0d expected 0f0f0f0f/0000 0", out_data, out_dbi, inv_count); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_tie();
    test_backpressure();
    test_saturation();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
